eth_avalon_bd_ram2: RTL
=======================

ETH_AVALON_BD_RAM2 -- requirements
Module: eth_avalon_bd_ram2

Interface
REQ-001 SHALL have parameter DEPTH, default 128, words per RAM (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 32, data bits per word (multiple of 8).
REQ-003 SHALL have parameter OUT_REG, default 0, 1 = extra output register stage on q_a/q_b.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero-fill RAM after reset.
REQ-005 SHALL have parameter A_PRIORITY, default 1, 1 = port A wins same-address write collision, 0 = port B wins.
REQ-006 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port busy  out  1  high while the clear sequence runs.
REQ-009 SHALL have port collision  out  1  one-cycle pulse on a same-address dual write.
REQ-010 SHALL have port rden_a / rden_b  in  1  read enable per port.
REQ-011 SHALL have port wren_a / wren_b  in  1  write enable per port.
REQ-012 SHALL have port byteen_a / byteen_b  in  WIDTH/8  byte write enables (bit i -> bits 8i+7:8i).
REQ-013 SHALL have port address_a / address_b  in  ADDR_W = clogb2(DEPTH-1)+1  word address.
REQ-014 SHALL have port data_a / data_b  in  WIDTH  write data.
REQ-015 SHALL have port q_a / q_b  out  WIDTH  read data.

Function
REQ-016 Clear FSM SHALL have states RST, CLEAR, READY: RST on reset_n=0; RST->CLEAR on first cycle with reset_n=1 if CLEAR_ON_RESET=1, else RST->READY.
REQ-017 In CLEAR, SHALL write all-zero to address cnt, cnt counting 0..DEPTH-1, one word per cycle; CLEAR->READY after cnt=DEPTH-1 written (exactly DEPTH cycles).
REQ-018 busy SHALL be 1 in RST and CLEAR, 0 in READY.
REQ-019 While busy=1, all port writes SHALL be dropped and reads ignored (q holds 0).
REQ-020 In READY, a write SHALL update only bytes whose byteen bit is 1; byteen=0 with wren=1 leaves the word unchanged.
REQ-021 Read with rden=1 SHALL present ram[address] on q one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1); with rden=0, q SHALL hold its previous value.
REQ-022 Same-port read-during-write SHALL return the old (pre-write) word.
REQ-023 Mixed-port read of an address written by the other port in the same cycle SHALL return the old word.
REQ-024 Both ports writing the same address in the same cycle SHALL commit only the priority port's enabled bytes (loser's bytes entirely dropped) and pulse collision for exactly one cycle, registered (asserted the cycle after).
REQ-025 Writes to different addresses in the same cycle SHALL both commit; collision stays 0.
REQ-026 Addresses SHALL be used modulo DEPTH; no out-of-range behaviour exists.

Reset
REQ-027 reset_n=0 at any clock edge, including mid-CLEAR, SHALL force state RST, cnt=0, busy=1, collision=0, q_a=q_b=0 (both pipeline stages); clear restarts from address 0.
REQ-028 RAM contents SHALL NOT be reset directly; only the clear sequence zeroes them (contents undefined when CLEAR_ON_RESET=0).

Structure
REQ-029 Function clogb2 and the FSM state encoding (RST=2'd0, CLEAR=2'd1, READY=2'd2) SHALL live in shared package eth_avalon_pkg.
REQ-030 Clear FSM and counter SHALL be sub-module eth_avalon_bd_ram_clr (outputs busy, clr_we, clr_addr); the storage array and port muxing stay in the top.
REQ-031 Storage SHALL be inferable as true dual-port block RAM with byte enables; collision masking SHALL be done before the array write.

Verification
REQ-032 Release reset, DEPTH=128: busy=1 for exactly 128 cycles then 0; read every address -> 0x00000000.
REQ-033 Write A addr 5 = 0xDEADBEEF byteen=4'b1111, then A addr 5 = 0x11223344 byteen=4'b0011 -> read B addr 5 = 0xDEAD3344, latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
REQ-034 Same cycle A writes addr 9 = 0xAAAAAAAA, B writes addr 9 = 0x55555555, A_PRIORITY=1 -> collision=1 next cycle only, ram[9]=0xAAAAAAAA; A_PRIORITY=0 -> 0x55555555.
REQ-035 ram[3]=0x1; A writes 0x2 to addr 3 while B reads addr 3 same cycle -> q_b=0x1; next read -> 0x2.
REQ-036 Assert reset_n=0 at clear cycle 60 for one cycle -> busy stays 1, clear restarts, READY after 128 more cycles; write attempted during busy has no effect.

Source files
------------

// File: rtl/eth_avalon_pkg.sv
// Shared definitions for the Avalon buffer-descriptor RAM: clear-FSM state codes
// and the address-width helper.
package eth_avalon_pkg;

   localparam logic [1:0] StRst   = 2'd0;
   localparam logic [1:0] StClear = 2'd1;
   localparam logic [1:0] StReady = 2'd2;

   // Index of the most significant set bit; clogb2(DEPTH-1)+1 gives the word address width.
   function automatic int clogb2(input int value);
      int r;
      int v;
      r = 0;
      v = value;
      while (v > 1) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_avalon_bd_ram_clr.sv
// Post-reset clear sequencer: walks every word address once, then reports ready.
module eth_avalon_bd_ram_clr
   import eth_avalon_pkg::*;
#(
   parameter int DEPTH          = 128,
   parameter int CLEAR_ON_RESET = 1,
   parameter int ADDR_W         = 7
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StRst: begin
            state_d = (CLEAR_ON_RESET != 0) ? StClear : StReady;
            cnt_d   = '0;
         end
         StClear: begin
            if (cnt_q == LastAddr) begin
               state_d = StReady;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StReady: ;
         default: state_d = StRst;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StRst;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy     = (state_q != StReady);
   assign clr_we   = (state_q == StClear);
   assign clr_addr = cnt_q;

endmodule

// File: rtl/eth_avalon_bd_ram2.sv
// True dual-port byte-enabled descriptor RAM with post-reset zero fill, same-address
// write arbitration and optional output register stage.
module eth_avalon_bd_ram2
   import eth_avalon_pkg::*;
#(
   parameter int DEPTH          = 128,
   parameter int WIDTH          = 32,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int A_PRIORITY     = 1,
   localparam int ADDR_W        = clogb2(DEPTH - 1) + 1,
   localparam int BE_W          = WIDTH / 8
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              busy,
   output logic              collision,
   input  logic              rden_a,
   input  logic              rden_b,
   input  logic              wren_a,
   input  logic              wren_b,
   input  logic [BE_W-1:0]   byteen_a,
   input  logic [BE_W-1:0]   byteen_b,
   input  logic [ADDR_W-1:0] address_a,
   input  logic [ADDR_W-1:0] address_b,
   input  logic [WIDTH-1:0]  data_a,
   input  logic [WIDTH-1:0]  data_b,
   output logic [WIDTH-1:0]  q_a,
   output logic [WIDTH-1:0]  q_b
);

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   eth_avalon_bd_ram_clr #(
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET),
      .ADDR_W         (ADDR_W)
   ) u_clr (
      .clock    (clock),
      .reset_n  (reset_n),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic              we_a, we_b, coll_d, collision_q;
   logic [BE_W-1:0]   be_a, be_b;
   logic [ADDR_W-1:0] wa;
   logic [WIDTH-1:0]  wd_a;

   // Clear sequence borrows port A; collision losers are masked so the array never
   // sees two writes to one word.
   always_comb begin
      coll_d = !busy && wren_a && wren_b && (address_a == address_b);
      if (clr_we) begin
         we_a = 1'b1;
         wa   = clr_addr;
         wd_a = '0;
         be_a = '1;
      end else begin
         we_a = wren_a && !busy;
         wa   = address_a;
         wd_a = data_a;
         be_a = byteen_a;
      end
      we_b = wren_b && !busy;
      be_b = byteen_b;
      if (coll_d) begin
         if (A_PRIORITY != 0) be_b = '0;
         else                 be_a = '0;
      end
   end

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we_a && be_a[i]) mem[wa][8*i +: 8] <= wd_a[8*i +: 8];
         if (we_b && be_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
      end
   end

   logic [WIDTH-1:0] rd_a_q, rd_b_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         collision_q <= 1'b0;
      end else begin
         if (rden_a && !busy) rd_a_q <= mem[address_a];
         if (rden_b && !busy) rd_b_q <= mem[address_b];
         collision_q <= coll_d;
      end
   end

   assign collision = collision_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] q_a_q, q_b_q;
      always_ff @(posedge clock) begin
         if (!reset_n) begin
            q_a_q <= '0;
            q_b_q <= '0;
         end else begin
            q_a_q <= rd_a_q;
            q_b_q <= rd_b_q;
         end
      end
      assign q_a = q_a_q;
      assign q_b = q_b_q;
   end else begin : g_no_out_reg
      assign q_a = rd_a_q;
      assign q_b = rd_b_q;
   end

endmodule
